// File: rtl/gs_project_pkg.sv
// rtl/gs_project_pkg.sv - shared types, widths and saturation helpers for the projection stage
package gs_project_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DOT   = 2'd1,
      ST_SCALE = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 16;
   localparam int FBITS_DEF = 8;
   // Common signed width used for all intermediate saturation checks (supports WIDTH <= 31)
   localparam int EXTW = 64;

   // Accumulator width: four full-precision products plus two guard bits never wrap
   function automatic int accw(input int w);
      return 2 * w + 2;
   endfunction

   function automatic logic signed [EXTW-1:0] max_v(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [EXTW-1:0] min_v(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   function automatic logic signed [EXTW-1:0] sat_to_width(input logic signed [EXTW-1:0] x,
                                                           input int w);
      if (x > max_v(w)) return max_v(w);
      if (x < min_v(w)) return min_v(w);
      return x;
   endfunction

   function automatic logic is_clip(input logic signed [EXTW-1:0] x, input int w);
      return (x > max_v(w)) || (x < min_v(w));
   endfunction

endpackage

// File: rtl/gs_project_if.sv
// rtl/gs_project_if.sv - operand/result bundle between normaliser and projection stage
interface gs_project_if #(parameter int WIDTH = 16);
   logic                    start;
   logic signed [WIDTH-1:0] q1, q2, q3, q4;
   logic signed [WIDTH-1:0] h1, h2, h3, h4;
   logic                    busy;
   logic                    valid;
   logic                    ovf;
   logic signed [WIDTH-1:0] r12;
   logic signed [WIDTH-1:0] u1, u2, u3, u4;

   modport master (
      output start, q1, q2, q3, q4, h1, h2, h3, h4,
      input  busy, valid, ovf, r12, u1, u2, u3, u4
   );

   modport slave (
      input  start, q1, q2, q3, q4, h1, h2, h3, h4,
      output busy, valid, ovf, r12, u1, u2, u3, u4
   );
endinterface

// File: rtl/fxp_mul.sv
// rtl/fxp_mul.sv - combinational signed fixed-point multiplier with rescale and saturation
module fxp_mul
   import gs_project_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int FBITS = FBITS_DEF
) (
   input  logic signed [WIDTH-1:0]   i_a,
   input  logic signed [WIDTH-1:0]   i_b,
   output logic signed [2*WIDTH-1:0] o_prod,
   output logic signed [WIDTH-1:0]   o_res,
   output logic                      o_clip
);

   logic signed [2*WIDTH-1:0] w_a_ext;
   logic signed [2*WIDTH-1:0] w_b_ext;
   logic signed [2*WIDTH-1:0] w_sh;
   logic signed [EXTW-1:0]    w_sh_ext;

   // Operands are sign-extended first so the low 2*WIDTH bits hold the exact product
   assign w_a_ext  = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_b_ext  = {{WIDTH{i_b[WIDTH-1]}}, i_b};
   assign o_prod   = w_a_ext * w_b_ext;
   assign w_sh     = o_prod >>> FBITS;
   assign w_sh_ext = {{(EXTW-2*WIDTH){w_sh[2*WIDTH-1]}}, w_sh};
   assign o_res    = WIDTH'(sat_to_width(w_sh_ext, WIDTH));
   assign o_clip   = is_clip(w_sh_ext, WIDTH);

endmodule

// File: rtl/gs_project.sv
// rtl/gs_project.sv - Gram-Schmidt projection: r12 = <q,h>, u = h - r12*q on one shared multiplier
module gs_project
   import gs_project_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int FBITS = FBITS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   gs_project_if.slave bus
);

   localparam int ACCW = accw(WIDTH);

   state_t                  r_state;
   logic [1:0]              r_idx;
   logic signed [WIDTH-1:0] r_q     [4];
   logic signed [WIDTH-1:0] r_h     [4];
   logic signed [WIDTH-1:0] r_u     [4];
   logic signed [WIDTH-1:0] r_u_out [4];
   logic signed [ACCW-1:0]  r_acc;
   logic signed [WIDTH-1:0] r_r;
   logic signed [WIDTH-1:0] r_r12;
   logic                    r_ovf_ip;
   logic                    r_busy;
   logic                    r_valid;
   logic                    r_ovf;

   logic                      w_scale;
   logic signed [WIDTH-1:0]   w_mul_a;
   logic signed [WIDTH-1:0]   w_mul_b;
   logic signed [2*WIDTH-1:0] w_prod;
   logic signed [WIDTH-1:0]   w_mul_res;
   logic                      w_mul_clip;

   // DOT multiplies q*h, SCALE multiplies r*q; the single multiplier is steered by state
   assign w_scale = (r_state == ST_SCALE);
   assign w_mul_a = w_scale ? r_r : r_q[r_idx];
   assign w_mul_b = w_scale ? r_q[r_idx] : r_h[r_idx];

   fxp_mul #(.WIDTH(WIDTH), .FBITS(FBITS)) u_mul (
      .i_a    (w_mul_a),
      .i_b    (w_mul_b),
      .o_prod (w_prod),
      .o_res  (w_mul_res),
      .o_clip (w_mul_clip)
   );

   logic signed [ACCW-1:0]  w_acc_next;
   logic signed [ACCW-1:0]  w_acc_sh;
   logic signed [EXTW-1:0]  w_acc_ext;
   logic signed [WIDTH-1:0] w_r_sat;
   logic                    w_r_clip;

   // Final accumulate, rescale and clip of the dot product, used on the last DOT edge
   assign w_acc_next = r_acc + {{2{w_prod[2*WIDTH-1]}}, w_prod};
   assign w_acc_sh   = w_acc_next >>> FBITS;
   assign w_acc_ext  = {{(EXTW-ACCW){w_acc_sh[ACCW-1]}}, w_acc_sh};
   assign w_r_sat    = WIDTH'(sat_to_width(w_acc_ext, WIDTH));
   assign w_r_clip   = is_clip(w_acc_ext, WIDTH);

   logic signed [EXTW-1:0]  w_h_ext;
   logic signed [EXTW-1:0]  w_m_ext;
   logic signed [EXTW-1:0]  w_diff;
   logic signed [WIDTH-1:0] w_u_sat;
   logic                    w_u_clip;

   // Residual element: h - sat(r*q); either saturation flags overflow
   assign w_h_ext  = {{(EXTW-WIDTH){r_h[r_idx][WIDTH-1]}}, r_h[r_idx]};
   assign w_m_ext  = {{(EXTW-WIDTH){w_mul_res[WIDTH-1]}}, w_mul_res};
   assign w_diff   = w_h_ext - w_m_ext;
   assign w_u_sat  = WIDTH'(sat_to_width(w_diff, WIDTH));
   assign w_u_clip = is_clip(w_diff, WIDTH) | w_mul_clip;

   // Control FSM and datapath registers; results are published only on completion
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= 2'd0;
         r_acc    <= '0;
         r_r      <= '0;
         r_r12    <= '0;
         r_ovf_ip <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_q[i]     <= '0;
            r_h[i]     <= '0;
            r_u[i]     <= '0;
            r_u_out[i] <= '0;
         end
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_q[0]   <= bus.q1;
                  r_q[1]   <= bus.q2;
                  r_q[2]   <= bus.q3;
                  r_q[3]   <= bus.q4;
                  r_h[0]   <= bus.h1;
                  r_h[1]   <= bus.h2;
                  r_h[2]   <= bus.h3;
                  r_h[3]   <= bus.h4;
                  r_acc    <= '0;
                  r_ovf_ip <= 1'b0;
                  r_idx    <= 2'd0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_DOT;
               end
            end
            ST_DOT: begin
               r_acc <= w_acc_next;
               r_idx <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  r_r <= w_r_sat;
                  if (w_r_clip) r_ovf_ip <= 1'b1;
                  r_state <= ST_SCALE;
               end
            end
            ST_SCALE: begin
               r_u[r_idx] <= w_u_sat;
               if (w_u_clip) r_ovf_ip <= 1'b1;
               r_idx <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  r_r12      <= r_r;
                  r_u_out[0] <= r_u[0];
                  r_u_out[1] <= r_u[1];
                  r_u_out[2] <= r_u[2];
                  r_u_out[3] <= w_u_sat;
                  r_ovf      <= r_ovf_ip | w_u_clip;
                  r_valid    <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.valid = r_valid;
   assign bus.ovf   = r_ovf;
   assign bus.r12   = r_r12;
   assign bus.u1    = r_u_out[0];
   assign bus.u2    = r_u_out[1];
   assign bus.u3    = r_u_out[2];
   assign bus.u4    = r_u_out[3];

endmodule
